conv_pool_sequencer: RTL and testbench

- Sequences a binary input feature map through the combinational conv+pool channel datapath, one window at a time.
- Buffers 6 input rows at a time and drives each 6x6 window to the datapath, with a stride of 2 in both axes.
- Captures the CHAN_OUT-bit pooled result and emits it on a valid/ready output stream, tagged with output coordinates.
- Sits between the row-stream source (input map memory) and the next layer's buffer.

---
 rtl/conv_pool_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_conv_pool_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_sequencer.sv
// Purpose: walks a 6x6, stride-2 window over a binary input map and drives it to a combinational conv+pool datapath.
// Latency: first result 8 cycles after start (DP_LAT=1); 2 cycles per further output, plus 2 LOAD cycles + 2 per new band.
// Backpressure: row input stalls on row_valid gaps; the output holds pixel and coordinates until out_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start/busy/done     frame start pulse (IDLE only), busy level, one-cycle completion pulse
//   row_data/valid/ready  input row stream; bit c of row_data is column c; ready only while loading rows
//   win, dp_pixel       6x6 window to the datapath (bit r*6+c) and its CHAN_OUT-bit result
//   out_pixel/x/y       registered result tagged with its output coordinates
//   out_valid/ready     output stream handshake
module conv_pool_sequencer #(
  parameter int IN_W     = 12,
  parameter int IN_H     = 12,
  parameter int CHAN_OUT = 18,
  parameter int DP_LAT   = 1,
  localparam int OUT_W   = (IN_W - 6) / 2 + 1,
  localparam int OUT_H   = (IN_H - 6) / 2 + 1,
  localparam int XW      = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int YW      = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic [IN_W-1:0]     row_data,
  input  logic                row_valid,
  output logic                row_ready,
  output logic [35:0]         win,
  input  logic [CHAN_OUT-1:0] dp_pixel,
  output logic [CHAN_OUT-1:0] out_pixel,
  output logic [XW-1:0]       out_x,
  output logic [YW-1:0]       out_y,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int LW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(OUT_H - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(DP_LAT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WIN  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q;
  logic [2:0]            need_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [LW-1:0]         lat_q;
  logic [IN_W-1:0]       rows_q [6];
  logic [35:0]           win_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  row_ready_q;
  logic                  out_valid_q;
  logic [CHAN_OUT-1:0]   out_pixel_q;
  logic [XW-1:0]         out_x_q;
  logic [YW-1:0]         out_y_q;

  // Next window contents. Two ways into WIN: from LOAD, where the window must
  // include the row being accepted this cycle at x=0, and from OUT, where the
  // buffer is unchanged and the window slides one output column (2 input columns).
  logic [IN_W-1:0]       rows_sh [6];
  logic [IN_W-1:0]       src_row;
  logic [XW-1:0]         src_x;
  logic [IN_W-1:0]       col_sh;
  logic [35:0]           win_d;

  always_comb begin
    src_row = '0;
    col_sh  = '0;
    win_d   = '0;
    for (int r = 0; r < 5; r++) begin
      rows_sh[r] = rows_q[r+1];
    end
    rows_sh[5] = row_data;
    src_x = (state_q == LOAD) ? '0 : x_q + 1'b1;
    for (int r = 0; r < 6; r++) begin
      src_row = (state_q == LOAD) ? rows_sh[r] : rows_q[r];
      col_sh  = src_row >> {src_x, 1'b0};
      win_d[r*6 +: 6] = col_sh[5:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      need_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lat_q       <= '0;
      for (int r = 0; r < 6; r++) begin
        rows_q[r] <= '0;
      end
      win_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            need_q      <= 3'd6;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b1;
            row_ready_q <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (row_valid) begin
            for (int r = 0; r < 6; r++) begin
              rows_q[r] <= rows_sh[r];
            end
            need_q <= need_q - 3'd1;
            if (need_q == 3'd1) begin
              row_ready_q <= 1'b0;
              win_q       <= win_d;
              lat_q       <= '0;
              state_q     <= WIN;
            end
          end
        end
        WIN: begin
          // win has been stable for DP_LAT cycles when lat_q hits the last count
          if (lat_q == LAT_LAST) begin
            out_pixel_q <= dp_pixel;
            out_x_q     <= x_q;
            out_y_q     <= y_q;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (x_q != X_LAST) begin
              x_q     <= x_q + 1'b1;
              win_q   <= win_d;
              lat_q   <= '0;
              state_q <= WIN;
            end else if (y_q != Y_LAST) begin
              // next band reuses the bottom 4 rows; only 2 fresh rows needed
              x_q         <= '0;
              y_q         <= y_q + 1'b1;
              need_q      <= 3'd2;
              row_ready_q <= 1'b1;
              state_q     <= LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign row_ready = row_ready_q;
  assign win       = win_q;
  assign out_pixel = out_pixel_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_pool_sequencer.sv
`timescale 1ns/1ps
module tb_conv_pool_sequencer;
  localparam int IN_W  = 12;
  localparam int IN_H  = 12;
  localparam int CH    = 18;
  localparam int OUT_W = 4;
  localparam int OUT_H = 4;
  localparam int NOUT  = OUT_W * OUT_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic row_valid = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;
  logic [IN_W-1:0] row_data = '0;

  logic busy1, done1, rr1, ov1, busy3, done3, rr3, ov3;
  logic [35:0] win1, win3, w3d1, w3d2;
  logic [CH-1:0] dp1, dp3, op1, op3;
  logic [1:0] ox1, oy1, ox3, oy3;

  logic busy_m, done_m, rr_m, ov_m;
  logic [35:0] win_m;
  logic [CH-1:0] op_m;
  logic [1:0] ox_m, oy_m;

  logic [IN_W-1:0] map [IN_H];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Reference datapath: channel k sees window bit k, folded with the upper half,
  // plus an AND-reduce term so an all-ones window gives all-ones.
  function automatic logic [CH-1:0] gfun(input logic [35:0] w);
    return w[17:0] ^ {w[26:18], w[35:27]} ^ {CH{&w}};
  endfunction

  // Slow datapath for the DP_LAT=3 instance: only from the 3rd cycle of a
  // window onward do all three terms agree and collapse to gfun(win).
  always @(posedge clk) begin
    w3d1 <= win3;
    w3d2 <= w3d1;
  end
  assign dp1 = gfun(win1);
  assign dp3 = gfun(win3) ^ gfun(w3d1) ^ gfun(w3d2);

  conv_pool_sequencer #(.IN_W(IN_W), .IN_H(IN_H), .CHAN_OUT(CH), .DP_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy1), .done(done1),
    .row_data(row_data), .row_valid(row_valid & ~sel), .row_ready(rr1),
    .win(win1), .dp_pixel(dp1), .out_pixel(op1), .out_x(ox1), .out_y(oy1),
    .out_valid(ov1), .out_ready(out_ready)
  );

  conv_pool_sequencer #(.IN_W(IN_W), .IN_H(IN_H), .CHAN_OUT(CH), .DP_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start & sel), .busy(busy3), .done(done3),
    .row_data(row_data), .row_valid(row_valid & sel), .row_ready(rr3),
    .win(win3), .dp_pixel(dp3), .out_pixel(op3), .out_x(ox3), .out_y(oy3),
    .out_valid(ov3), .out_ready(out_ready)
  );

  assign busy_m = sel ? busy3 : busy1;
  assign done_m = sel ? done3 : done1;
  assign rr_m   = sel ? rr3   : rr1;
  assign ov_m   = sel ? ov3   : ov1;
  assign win_m  = sel ? win3  : win1;
  assign op_m   = sel ? op3   : op1;
  assign ox_m   = sel ? ox3   : ox1;
  assign oy_m   = sel ? oy3   : oy1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Window (x,y) straight from the map: rows 2y..2y+5, columns 2x..2x+5.
  function automatic logic [35:0] mwin(input int x, input int y);
    logic [35:0] w;
    logic [IN_W-1:0] rv;
    w = '0;
    for (int r = 0; r < 6; r++) begin
      rv = map[2*y + r];
      for (int c = 0; c < 6; c++) w[r*6 + c] = rv[2*x + c];
    end
    return w;
  endfunction

  typedef struct {
    int kind;       // 0 all ones, 1 single bit at row 7 col 9, 2 random
    bit tog;        // row_valid toggles every cycle
    int bp_idx;     // output index held off by out_ready=0 (-1 none)
    int bp_len;
    int rst_idx;    // assert reset while this output is presented (-1 none)
    bit lat3;       // use the DP_LAT=3 instance
    int exp_outs;   // handshakes expected
    int exp_first;  // cycle of first out_valid (-1 unchecked)
    int exp_done;   // cycle of done pulse (-1 unchecked)
  } vec_t;

  task automatic run(input vec_t v);
    int cyc, row_i, out_i, done_cnt, bp_cnt, first_cyc, done_cyc;
    bit fin, aborted, after_done;
    logic [35:0] ew;
    cyc = 0; row_i = 0; out_i = 0; done_cnt = 0; bp_cnt = 0;
    first_cyc = -1; done_cyc = -1;
    fin = 0; aborted = 0; after_done = 0;
    sel = v.lat3;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; row_valid = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);  // stray start while busy must be ignored
      if (after_done) begin
        chk("busy_after_done", busy_m, 0);
        chk("done_one_cycle", done_m, 0);
        fin = 1;
      end else begin
        if (rr_m) chk("row_ready_only_load", {busy_m, ov_m}, 2'b10);
        if (done_m) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_last", out_i, v.exp_outs);
          after_done = 1;
        end
        out_ready = 1'b1;
        if (ov_m && out_i < NOUT) begin
          if (first_cyc < 0) first_cyc = cyc;
          ew = mwin(out_i % OUT_W, out_i / OUT_W);
          chk($sformatf("win[%0d]", out_i), win_m, ew);
          chk($sformatf("pix[%0d]", out_i), op_m, gfun(ew));
          chk($sformatf("x[%0d]", out_i), ox_m, out_i % OUT_W);
          chk($sformatf("y[%0d]", out_i), oy_m, out_i / OUT_W);
          if (out_i == v.rst_idx) begin
            rst = 1'b1;
            #1;
            chk("rst_async_outputs", {busy_m, done_m, rr_m, ov_m, op_m, ox_m, oy_m, win_m}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            start = 1'b0;
            repeat (2) @(negedge clk);
            chk("idle_after_rst", {busy_m, rr_m, ov_m}, 3'b000);
            aborted = 1;
            fin = 1;
          end else begin
            if (out_i == v.bp_idx && bp_cnt < v.bp_len) begin
              out_ready = 1'b0;
              bp_cnt++;
            end
            if (out_ready) out_i++;
          end
        end else if (ov_m) begin
          out_i++;  // surplus output: shows up in the final count
        end
        row_valid = v.tog ? cyc[0] : 1'b1;
        row_data  = (row_i < IN_H) ? map[row_i] : IN_W'($urandom);
        if (rr_m && row_valid && !aborted) row_i++;
      end
    end
    start = 1'b0;
    row_valid = 1'b0;
    chk("frame_finished", fin, 1);
    chk("outputs", out_i, v.exp_outs);
    if (!aborted) begin
      chk("done_count", done_cnt, 1);
      chk("rows_accepted", row_i, IN_H);
      if (v.exp_first >= 0) chk("first_valid_cycle", first_cyc, v.exp_first);
      if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    end
  endtask

  initial begin
    vec_t tv[8];
    // first out_valid at 7+DP_LAT; each output costs DP_LAT+1; each extra band 2 more; done one cycle after the last
    tv[0] = '{0, 1'b0, -1, 0, -1, 1'b0, NOUT, 8, 8 + 15*2 + 3*2 + 1};
    tv[1] = '{1, 1'b0, -1, 0, -1, 1'b0, NOUT, 8, 45};
    tv[2] = '{2, 1'b0,  2, 5, -1, 1'b0, NOUT, 8, 45 + 5};
    tv[3] = '{2, 1'b1, -1, 0, -1, 1'b0, NOUT, -1, -1};
    tv[4] = '{2, 1'b0, -1, 0, -1, 1'b1, NOUT, 10, 10 + 15*4 + 3*2 + 1};
    tv[5] = '{2, 1'b0, -1, 0,  5, 1'b0, 5, -1, -1};
    tv[6] = '{2, 1'b0, -1, 0, -1, 1'b0, NOUT, 8, 45};
    tv[7] = '{2, 1'b1,  2, 5, -1, 1'b1, NOUT, -1, -1};

    #1;
    chk("reset_dut1", {busy1, done1, rr1, ov1, op1, ox1, oy1, win1}, 64'd0);
    chk("reset_dut3", {busy3, done3, rr3, ov3, op3, ox3, oy3, win3}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < IN_H; r++) begin
        case (tv[t].kind)
          0: map[r] = '1;
          1: map[r] = (r == 7) ? IN_W'(1 << 9) : '0;
          default: map[r] = IN_W'($urandom);
        endcase
      end
      run(tv[t]);
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
